mmio_responder: RTL and testbench

- Memory-mapped peripheral responder on the CPU data bus; the target end of the CPU's load/store request interface.
- Accepts one request at a time over a valid/ready request channel and returns one response per request over a valid/ready response channel.
- Owns the board-visible LED and output_peripherals registers, a free-running timer with compare flag, and the timer interrupt line.

---
 rtl/mmio_pkg.sv | 19 +
 rtl/mmio_responder_if.sv | 28 ++
 rtl/mmio_timer.sv | 41 ++++
 rtl/mmio_responder.sv | 122 ++++++++++++
 tb/tb_mmio_responder.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: register offsets, window size
// and the request/response FSM encoding.
package mmio_pkg;

  localparam logic [4:0] LED_OFF    = 5'h00;
  localparam logic [4:0] PERIPH_OFF = 5'h04;
  localparam logic [4:0] TOGGLE_OFF = 5'h08;
  localparam logic [4:0] TIMER_OFF  = 5'h0C;
  localparam logic [4:0] CMP_OFF    = 5'h10;
  localparam logic [4:0] STATUS_OFF = 5'h14;

  localparam int unsigned WINDOW_SIZE = 32'h20;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } mmio_state_e;

endpackage

// File: rtl/mmio_responder_if.sv
// CPU load/store bus between a requester (master) and the MMIO responder (slave).
// Handshake: a beat transfers on a rising edge where valid && ready; the sender
// holds valid and its payload stable until that edge, and ready never waits on valid.
interface mmio_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            req_wstrb;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/mmio_timer.sv
// Free-running 32-bit timer with a byte-writable compare register and a
// sticky match flag (write-1-to-clear, a new match beats a clear).
module mmio_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmp_we,
  input  logic [31:0] cmp_wdata,
  input  logic [3:0]  cmp_wstrb,
  input  logic        clear,
  output logic [31:0] timer_value,
  output logic [31:0] cmp_value,
  output logic        flag
);

  logic [31:0] timer_q;
  logic [31:0] cmp_q;
  logic        flag_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      flag_q  <= 1'b0;
    end else begin
      timer_q <= timer_q + 32'd1;
      if (cmp_we) begin
        for (int b = 0; b < 4; b++) begin
          if (cmp_wstrb[b]) cmp_q[8*b +: 8] <= cmp_wdata[8*b +: 8];
        end
      end
      // Compare uses the pre-write compare value, so a store alone never sets the flag.
      if (timer_q == cmp_q) flag_q <= 1'b1;
      else if (clear)       flag_q <= 1'b0;
    end
  end

  assign timer_value = timer_q;
  assign cmp_value   = cmp_q;
  assign flag        = flag_q;

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: one-outstanding-request FSM, register decode, LED/PERIPH
// registers, and the timer sub-block.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter int          LED_WIDTH    = 6,
  parameter int          PERIPH_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  mmio_responder_if.slave         bus,
  output logic [LED_WIDTH-1:0]    led,
  output logic [PERIPH_WIDTH-1:0] output_peripherals,
  output logic                    timer_irq,
  output mmio_state_e             dbg_state
);

  mmio_state_e             state_q, state_d;
  logic                    accept, in_window, req_err, wr_hit;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [4:0]              reg_off;
  logic [LED_WIDTH-1:0]    led_reg, led_next;
  logic [PERIPH_WIDTH-1:0] periph_reg, periph_next;
  logic [DATA_WIDTH-1:0]   rdata_d;
  logic [31:0]             timer_value, cmp_value;
  logic                    flag;

  // Subtraction wraps addresses below the base to large offsets, so one compare bounds both ends.
  assign offset    = bus.req_addr - ADDR_WIDTH'(BASE_ADDR);
  assign in_window = offset < ADDR_WIDTH'(WINDOW_SIZE);
  assign reg_off   = offset[4:0];
  assign req_err   = !in_window || (bus.req_addr[1:0] != 2'b00) || (reg_off >= 5'h18);
  assign accept    = bus.req_valid && (state_q == IDLE);
  assign wr_hit    = accept && bus.req_write && !req_err;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    dbg_state      = state_q;
  end

  always_comb begin
    led_next    = led_reg;
    periph_next = periph_reg;
    if (wr_hit) begin
      case (reg_off)
        LED_OFF:    for (int i = 0; i < LED_WIDTH; i++)
                      if (bus.req_wstrb[i[4:3]]) led_next[i] = bus.req_wdata[i];
        TOGGLE_OFF: for (int i = 0; i < LED_WIDTH; i++)
                      if (bus.req_wstrb[i[4:3]]) led_next[i] = led_reg[i] ^ bus.req_wdata[i];
        PERIPH_OFF: for (int i = 0; i < PERIPH_WIDTH; i++)
                      if (bus.req_wstrb[i[4:3]]) periph_next[i] = bus.req_wdata[i];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    if (!req_err && !bus.req_write) begin
      case (reg_off)
        LED_OFF:    rdata_d[LED_WIDTH-1:0]    = led_reg;
        PERIPH_OFF: rdata_d[PERIPH_WIDTH-1:0] = periph_reg;
        TIMER_OFF:  rdata_d                   = timer_value;
        CMP_OFF:    rdata_d                   = cmp_value;
        STATUS_OFF: rdata_d[0]                = flag;
        default: ;
      endcase
    end
  end

  // Response payload is latched at the accept edge and held through any resp_ready stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_reg        <= '0;
      periph_reg     <= '0;
      bus.resp_rdata <= '0;
      bus.resp_error <= 1'b0;
    end else begin
      led_reg    <= led_next;
      periph_reg <= periph_next;
      if (accept) begin
        bus.resp_rdata <= rdata_d;
        bus.resp_error <= req_err;
      end
    end
  end

  mmio_timer u_timer (
    .clock       (clock),
    .reset       (reset),
    .cmp_we      (wr_hit && (reg_off == CMP_OFF)),
    .cmp_wdata   (bus.req_wdata),
    .cmp_wstrb   (bus.req_wstrb),
    .clear       (wr_hit && (reg_off == STATUS_OFF) && bus.req_wstrb[0] && bus.req_wdata[0]),
    .timer_value (timer_value),
    .cmp_value   (cmp_value),
    .flag        (flag)
  );

  assign led                = ~led_reg;
  assign output_peripherals = periph_reg;
  assign timer_irq          = flag;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed scenarios plus randomized register traffic
// checked against a register-map model of the peripheral.
module tb_mmio_responder;
  import mmio_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  led;
  logic [3:0]  output_peripherals;
  logic        timer_irq;
  mmio_state_e dbg_state;

  always #5 clock = ~clock;

  mmio_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mmio_responder dut (
    .clock              (clock),
    .reset              (reset),
    .bus                (bus),
    .led                (led),
    .output_peripherals (output_peripherals),
    .timer_irq          (timer_irq),
    .dbg_state          (dbg_state)
  );

  // Reference time base: cycles elapsed since the last reset edge.
  logic [31:0] tb_timer;
  always @(posedge clock) tb_timer <= reset ? 32'd0 : tb_timer + 32'd1;

  int checks = 0;
  int errors = 0;

  logic [5:0]  m_led;
  logic [3:0]  m_periph;
  logic [31:0] m_cmp;
  logic        m_flag;
  logic [31:0] exp_q[$];

  logic [31:0] g_r, e_r, t_a, t_b;
  logic        g_e, e_e;

  // ---------------- clock/reset ----------------
  task automatic model_reset();
    m_led = '0; m_periph = '0; m_cmp = 32'hFFFF_FFFF; m_flag = 1'b0;
  endtask

  task automatic bus_idle();
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_wstrb = '0;   bus.resp_ready = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    bus_idle();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- driver ----------------
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata,
                      output logic err, output logic [31:0] t_acc);
    int n;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_wstrb = strb; bus.resp_ready = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: req_ready=%b required 1", bus.req_ready);
    end
    t_acc = tb_timer;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_latency: resp_valid=%b required 1 one cycle after accept", bus.resp_valid);
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_error;
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  task automatic model_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [31:0] t_acc,
                            output logic [31:0] exp_r, output logic exp_err);
    logic [31:0] off, old, merged, tgl;
    off     = addr - BASE;
    exp_r   = 32'd0;
    exp_err = (off >= 32'h20) || (addr[1:0] != 2'b00) || (off == 32'h18) || (off == 32'h1C);
    if (exp_err) return;
    case (off)
      32'h00:  old = {26'd0, m_led};
      32'h04:  old = {28'd0, m_periph};
      32'h10:  old = m_cmp;
      default: old = 32'd0;
    endcase
    merged = old;
    tgl    = 32'd0;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = wdata[8*b +: 8];
        tgl[8*b +: 8]    = wdata[8*b +: 8];
      end
    end
    if (wr) begin
      case (off)
        32'h00: m_led    = merged[5:0];
        32'h04: m_periph = merged[3:0];
        32'h08: m_led    = m_led ^ tgl[5:0];
        32'h10: m_cmp    = merged;
        32'h14: if (strb[0] && wdata[0]) m_flag = 1'b0;
        default: ;
      endcase
    end else begin
      case (off)
        32'h00: exp_r = {26'd0, m_led};
        32'h04: exp_r = {28'd0, m_periph};
        32'h0C: exp_r = t_acc;
        32'h10: exp_r = m_cmp;
        32'h14: exp_r = {31'd0, m_flag};
        default: exp_r = 32'd0;
      endcase
    end
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] t_acc);
    xfer(wr, addr, wdata, strb, g_r, g_e, t_acc);
    model_xfer(wr, addr, wdata, strb, t_acc, e_r, e_e);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    repeat (5) @(negedge clock);
    checks++; if (led !== 6'b111111) begin errors++; $display("FAIL reset_led: got %b required 111111", led); end
    checks++; if (output_peripherals !== 4'h0) begin errors++; $display("FAIL reset_periph: got %h required 0", output_peripherals); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b required 1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b required 0", bus.resp_valid); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", timer_irq); end
    checks++; if (bus.resp_rdata !== 32'd0 || bus.resp_error !== 1'b0) begin
      errors++; $display("FAIL reset_resp_payload: rdata=%h error=%b required 0/0", bus.resp_rdata, bus.resp_error);
    end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d required IDLE", dbg_state); end
  endtask

  task automatic test_random();
    logic [31:0] addr, wdata, prev_t, exp_r;
    logic        wr;
    logic [3:0]  strb;
    int          sel;
    prev_t = '0;
    for (int i = 0; i < 60; i++) begin
      sel  = $urandom_range(0, 9);
      addr = BASE + 32'($urandom_range(0, 7)) * 4;
      if (sel == 8) addr = addr + 32'($urandom_range(1, 3));
      if (sel == 9) addr = ($urandom_range(0, 1) == 1) ? BASE + 32'h20 + 32'($urandom_range(0, 15)) * 4
                                                       : BASE - 32'($urandom_range(1, 4)) * 4;
      wr    = 1'($urandom_range(0, 1));
      wdata = $urandom | 32'h8000_0000;  // keeps TIMER_CMP far above the timer
      strb  = 4'($urandom_range(0, 15));
      do_txn(wr, addr, wdata, strb, t_a);
      exp_q.push_back(e_r);
      exp_r = exp_q.pop_front();
      checks++; if (g_r !== exp_r) begin errors++; $display("FAIL rand_rdata[%0d]: addr=%h got %h required %h", i, addr, g_r, exp_r); end
      checks++; if (g_e !== e_e) begin errors++; $display("FAIL rand_error[%0d]: addr=%h got %b required %b", i, addr, g_e, e_e); end
      checks++; if (led !== ~m_led) begin errors++; $display("FAIL rand_led[%0d]: got %b required %b", i, led, ~m_led); end
      checks++; if (output_peripherals !== m_periph) begin errors++; $display("FAIL rand_periph[%0d]: got %h required %h", i, output_peripherals, m_periph); end
      if (i > 0) begin
        checks++; if (t_a - prev_t !== 32'd2) begin errors++; $display("FAIL back_to_back[%0d]: accept spacing %0d required 2", i, t_a - prev_t); end
      end
      prev_t = t_a;
    end
  endtask

  task automatic test_led();
    apply_reset();
    do_txn(1'b1, BASE + 32'h00, 32'h15, 4'hF, t_a);
    checks++; if (g_e !== 1'b0) begin errors++; $display("FAIL led_store_error: got %b required 0", g_e); end
    checks++; if (led !== 6'b101010) begin errors++; $display("FAIL led_store: got %b required 101010", led); end
    do_txn(1'b1, BASE + 32'h08, 32'h3F, 4'hF, t_a);
    checks++; if (led !== 6'b010101) begin errors++; $display("FAIL led_toggle: got %b required 010101", led); end
    do_txn(1'b0, BASE + 32'h08, 32'h0, 4'h0, t_a);
    checks++; if (g_r !== 32'd0) begin errors++; $display("FAIL toggle_read: got %h required 0", g_r); end
  endtask

  task automatic test_periph();
    do_txn(1'b1, BASE + 32'h04, 32'hA, 4'h0, t_a);
    checks++; if (output_peripherals !== 4'h0 || g_e !== 1'b0) begin
      errors++; $display("FAIL periph_strobe0: periph=%h error=%b required 0/0", output_peripherals, g_e);
    end
    do_txn(1'b1, BASE + 32'h04, 32'hA, 4'h1, t_a);
    checks++; if (output_peripherals !== 4'hA) begin errors++; $display("FAIL periph_store: got %h required a", output_peripherals); end
    do_txn(1'b0, BASE + 32'h04, 32'h0, 4'h0, t_a);
    checks++; if (g_r !== 32'h0000_000A) begin errors++; $display("FAIL periph_load: got %h required 0000000a", g_r); end
  endtask

  task automatic test_errors();
    logic [5:0] led_before;
    logic [3:0] per_before;
    do_txn(1'b1, BASE, 32'h2D, 4'hF, t_a);
    led_before = led;
    per_before = output_peripherals;
    do_txn(1'b0, BASE + 32'h18, 32'h0, 4'h0, t_a);
    checks++; if (g_e !== 1'b1 || g_r !== 32'd0) begin errors++; $display("FAIL err_unmapped: error=%b rdata=%h required 1/0", g_e, g_r); end
    do_txn(1'b0, BASE + 32'h02, 32'h0, 4'h0, t_a);
    checks++; if (g_e !== 1'b1 || g_r !== 32'd0) begin errors++; $display("FAIL err_misaligned: error=%b rdata=%h required 1/0", g_e, g_r); end
    do_txn(1'b1, BASE + 32'h40, 32'h3F, 4'hF, t_a);
    checks++; if (g_e !== 1'b1 || g_r !== 32'd0) begin errors++; $display("FAIL err_outside: error=%b rdata=%h required 1/0", g_e, g_r); end
    do_txn(1'b1, BASE + 32'h05, 32'hF, 4'hF, t_a);
    checks++; if (g_e !== 1'b1) begin errors++; $display("FAIL err_misaligned_store: error=%b required 1", g_e); end
    checks++; if (led !== led_before || led !== ~m_led) begin errors++; $display("FAIL err_led_changed: got %b required %b", led, ~m_led); end
    checks++; if (output_peripherals !== per_before || output_peripherals !== m_periph) begin
      errors++; $display("FAIL err_periph_changed: got %h required %h", output_peripherals, m_periph);
    end
  endtask

  task automatic test_timer();
    int early;
    apply_reset();
    do_txn(1'b1, BASE + 32'h10, 32'd40, 4'hF, t_a);
    early = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (tb_timer == 32'd40) break;
      if (timer_irq !== 1'b0) early++;
    end
    checks++; if (early != 0 || tb_timer != 32'd40) begin errors++; $display("FAIL irq_early: early=%0d timer=%0d required 0/40", early, tb_timer); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_at_match: got %b required 0", timer_irq); end
    @(negedge clock);
    m_flag = 1'b1;
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b required 1", timer_irq); end
    do_txn(1'b0, BASE + 32'h14, 32'h0, 4'h0, t_a);
    checks++; if (g_r !== e_r) begin errors++; $display("FAIL status_read: got %h required %h", g_r, e_r); end
    do_txn(1'b1, BASE + 32'h14, 32'h1, 4'hF, t_a);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b required 0", timer_irq); end
    do_txn(1'b0, BASE + 32'h0C, 32'h0, 4'h0, t_a);
    checks++; if (g_r !== e_r) begin errors++; $display("FAIL timer_read: got %0d required %0d", g_r, e_r); end
    t_b = g_r;
    repeat (3) @(posedge clock);
    do_txn(1'b0, BASE + 32'h0C, 32'h0, 4'h0, t_a);
    checks++; if (g_r - t_b !== 32'd5) begin errors++; $display("FAIL timer_delta: got %0d required 5", g_r - t_b); end
  endtask

  task automatic test_set_wins();
    logic [31:0] tgt;
    int n;
    tgt = tb_timer + 32'd30;
    do_txn(1'b1, BASE + 32'h10, tgt, 4'hF, t_a);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL cmp_store_no_set: got %b required 0", timer_irq); end
    n = 0;
    while (tb_timer != tgt - 32'd1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    do_txn(1'b1, BASE + 32'h14, 32'h1, 4'h1, t_a);
    m_flag = 1'b1;
    checks++; if (t_a !== tgt || timer_irq !== 1'b1) begin
      errors++; $display("FAIL set_beats_clear: accept=%0d irq=%b required %0d/1", t_a, timer_irq, tgt);
    end
  endtask

  task automatic test_hold();
    logic [31:0] exp_r;
    logic        exp_e;
    model_xfer(1'b0, BASE, 32'h0, 4'h0, tb_timer, exp_r, exp_e);
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = BASE; bus.resp_ready = 1'b0;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b required 1", k, bus.resp_valid); end
      checks++; if (bus.resp_rdata !== exp_r || bus.resp_error !== exp_e) begin
        errors++; $display("FAIL hold_payload[%0d]: got %h/%b required %h/%b", k, bus.resp_rdata, bus.resp_error, exp_r, exp_e);
      end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL hold_req_ready[%0d]: got %b required 0", k, bus.req_ready); end
    end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_abort: resp_valid=%b req_ready=%b required 0/1", bus.resp_valid, bus.req_ready);
    end
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    test_reset();
    test_random();
    test_led();
    test_periph();
    test_errors();
    test_timer();
    test_set_wins();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
